// File: rtl/elevator_car_controller.sv
// rtl/elevator_car_controller.sv - per-car motion and door controller
module elevator_car_controller #(
  parameter int TRAVEL_CYCLES = 100,
  parameter int DOOR_CYCLES   = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] assignedButton,
  input  logic [6:0]  carButton,
  output logic [2:0]  currentFloor,
  output logic [1:0]  direction,
  output logic        doorOpen,
  output logic [6:0]  carLamp,
  output logic [13:0] servedButton
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b01;

  // Floor 7 UP and floor 1 DOWN do not exist physically, so those bits never count.
  localparam logic [13:0] HALL_VALID = 14'b01_1111_1111_1110;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] counter, counterNext;
  logic [2:0]       floorNext;
  logic [1:0]       directionNext;
  logic             doorNext;
  logic [6:0]       lampNext, lampSet, lampClear;
  logic [13:0]      servedNext;

  logic [13:0] hallValid;
  logic [6:0]  hallUp, hallDown, floorReq;
  logic [2:0]  upFloor, downFloor;
  logic        reqHere, reqAboveCur, reqBelowCur, reqAboveUp, reqBelowDown;
  logic        stopUp, stopDown;

  // One-hot floor mask: floor f maps to bit f-1.
  function automatic logic [6:0] floorBit(input logic [2:0] f);
    logic [6:0] m;
    m = 7'd1 << (f - 3'd1);
    return m;
  endfunction

  // Floors strictly above f.
  function automatic logic [6:0] aboveMask(input logic [2:0] f);
    logic [6:0] m;
    m = 7'h7F << f;
    return m;
  endfunction

  // Floors strictly below f.
  function automatic logic [6:0] belowMask(input logic [2:0] f);
    logic [6:0] m;
    m = ~(7'h7F << (f - 3'd1));
    return m;
  endfunction

  // Hall UP bit of floor f in the 14-bit hall layout.
  function automatic logic [13:0] hallUpBit(input logic [2:0] f);
    logic [13:0] m;
    m = 14'd2 << {f - 3'd1, 1'b0};
    return m;
  endfunction

  // Hall DOWN bit of floor f in the 14-bit hall layout.
  function automatic logic [13:0] hallDownBit(input logic [2:0] f);
    logic [13:0] m;
    m = 14'd1 << {f - 3'd1, 1'b0};
    return m;
  endfunction

  // Split hall calls per floor and derive the request terms seen from here and from the neighbours.
  always_comb begin
    hallValid = assignedButton & HALL_VALID;
    for (int i = 0; i < 7; i++) begin
      hallUp[i]   = hallValid[2*i+1];
      hallDown[i] = hallValid[2*i];
    end
    floorReq  = carLamp | hallUp | hallDown;
    upFloor   = (currentFloor == 3'd7) ? 3'd7 : currentFloor + 3'd1;
    downFloor = (currentFloor == 3'd1) ? 3'd1 : currentFloor - 3'd1;

    reqHere      = |(floorReq & floorBit(currentFloor));
    reqAboveCur  = |(floorReq & aboveMask(currentFloor));
    reqBelowCur  = |(floorReq & belowMask(currentFloor));
    reqAboveUp   = |(floorReq & aboveMask(upFloor));
    reqBelowDown = |(floorReq & belowMask(downFloor));

    stopUp   = (|((carLamp | hallUp) & floorBit(upFloor))) | !reqAboveUp;
    stopDown = (|((carLamp | hallDown) & floorBit(downFloor))) | !reqBelowDown;
  end

  // Next-state, counter, output and car-lamp logic.
  always_comb begin
    stateNext     = state;
    counterNext   = counter;
    floorNext     = currentFloor;
    directionNext = direction;
    doorNext      = doorOpen;
    servedNext    = '0;
    lampClear     = '0;

    // A press for the floor whose door is already open is meaningless.
    lampSet = carButton & ~(doorOpen ? floorBit(currentFloor) : 7'd0);

    case (state)
      IDLE: begin
        directionNext = DIR_STOP;
        counterNext   = '0;
        if (reqHere) begin
          stateNext  = DOOR_OPEN;
          doorNext   = 1'b1;
          servedNext = hallValid & (hallUpBit(currentFloor) | hallDownBit(currentFloor));
          lampClear  = floorBit(currentFloor);
        end else if (reqAboveCur) begin
          stateNext     = MOVE_UP;
          directionNext = DIR_UP;
        end else if (reqBelowCur) begin
          stateNext     = MOVE_DOWN;
          directionNext = DIR_DOWN;
        end
      end

      MOVE_UP: begin
        if (counter == TRAVEL_LAST) begin
          floorNext   = upFloor;
          counterNext = '0;
          if (stopUp) begin
            stateNext = DOOR_OPEN;
            doorNext  = 1'b1;
            // Nothing further up means the car turns here, so the DOWN call is taken too.
            servedNext = hallValid & (hallUpBit(upFloor) |
                                      (reqAboveUp ? 14'd0 : hallDownBit(upFloor)));
            lampClear  = floorBit(upFloor);
          end
        end else begin
          counterNext = counter + CNT_W'(1);
        end
      end

      MOVE_DOWN: begin
        if (counter == TRAVEL_LAST) begin
          floorNext   = downFloor;
          counterNext = '0;
          if (stopDown) begin
            stateNext = DOOR_OPEN;
            doorNext  = 1'b1;
            servedNext = hallValid & (hallDownBit(downFloor) |
                                      (reqBelowDown ? 14'd0 : hallUpBit(downFloor)));
            lampClear  = floorBit(downFloor);
          end
        end else begin
          counterNext = counter + CNT_W'(1);
        end
      end

      DOOR_OPEN: begin
        if (counter == DOOR_LAST) begin
          doorNext    = 1'b0;
          counterNext = '0;
          if (direction == DIR_UP && reqAboveCur) begin
            stateNext = MOVE_UP;
          end else if (direction == DIR_DOWN && reqBelowCur) begin
            stateNext = MOVE_DOWN;
          end else if (reqAboveCur) begin
            stateNext     = MOVE_UP;
            directionNext = DIR_UP;
          end else if (reqBelowCur) begin
            stateNext     = MOVE_DOWN;
            directionNext = DIR_DOWN;
          end else begin
            // A call at this floor that arrived while the door was open reopens from IDLE.
            stateNext     = IDLE;
            directionNext = DIR_STOP;
          end
        end else begin
          counterNext = counter + CNT_W'(1);
        end
      end

      default: begin
        stateNext     = IDLE;
        directionNext = DIR_STOP;
        doorNext      = 1'b0;
        counterNext   = '0;
      end
    endcase

    lampNext = (carLamp | lampSet) & ~lampClear;
  end

  // State and output registers; reset abandons any move or door cycle and drops pending calls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      currentFloor <= 3'd1;
      direction    <= DIR_STOP;
      doorOpen     <= 1'b0;
      carLamp      <= '0;
      servedButton <= '0;
    end else begin
      state        <= stateNext;
      counter      <= counterNext;
      currentFloor <= floorNext;
      direction    <= directionNext;
      doorOpen     <= doorNext;
      carLamp      <= lampNext;
      servedButton <= servedNext;
    end
  end

endmodule

// File: tb/tb_elevator_car_controller.sv
// tb/tb_elevator_car_controller.sv - directed scoreboard bench for elevator_car_controller
module tb_elevator_car_controller;

  localparam int TRAVEL = 4;
  localparam int DOOR   = 6;

  logic        clk;
  logic        reset;
  logic [13:0] assignedButton;
  logic [6:0]  carButton;
  logic [2:0]  currentFloor;
  logic [1:0]  direction;
  logic        doorOpen;
  logic [6:0]  carLamp;
  logic [13:0] servedButton;

  elevator_car_controller #(
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES(DOOR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .assignedButton(assignedButton),
    .carButton(carButton),
    .currentFloor(currentFloor),
    .direction(direction),
    .doorOpen(doorOpen),
    .carLamp(carLamp),
    .servedButton(servedButton)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  flr;
    logic [13:0] served;
    logic [1:0]  dir;
  } stopT;

  stopT expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   doorRises  = 0;
  bit   autoClear  = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample away from the active edge; the dispatcher model drops served calls.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (autoClear) assignedButton = assignedButton & ~servedButton;
  endtask

  task automatic pushStop(input logic [2:0] f, input logic [13:0] s, input logic [1:0] d);
    stopT e;
    e.flr = f;
    e.served = s;
    e.dir = d;
    expQ.push_back(e);
  endtask

  task automatic waitFloor(input string tag, input logic [2:0] target, output int n);
    n = 0;
    while (currentFloor !== target && n < 100) begin
      tick();
      n++;
    end
    check(tag, currentFloor, target);
  endtask

  task automatic waitDoorCycle(input string tag);
    int n;
    n = 0;
    while (doorOpen !== 1'b1 && n < 300) begin tick(); n++; end
    while (doorOpen === 1'b1 && n < 300) begin tick(); n++; end
    check(tag, (n < 300), 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_floor"}, currentFloor, 3'd1);
    check({tag, "_dir"}, direction, 2'b00);
    check({tag, "_door"}, doorOpen, 1'b0);
    check({tag, "_lamp"}, carLamp, 7'd0);
    check({tag, "_served"}, servedButton, 14'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    carButton = '0;
    assignedButton = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard side: every door opening pops one expected stop; door length is checked on close.
  initial begin
    stopT e;
    bit   prevDoor;
    int   doorLen;
    prevDoor = 1'b0;
    doorLen  = 0;
    forever begin
      @(negedge clk);
      if (doorOpen === 1'b1 && !prevDoor) begin
        doorRises++;
        check("stop_expected", (expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          check("stop_floor", currentFloor, e.flr);
          check("stop_served", servedButton, e.served);
          check("stop_dir", direction, e.dir);
        end
      end
      if (doorOpen === 1'b1) doorLen++;
      else if (doorLen != 0) begin
        check("door_length", doorLen, DOOR);
        doorLen = 0;
      end
      prevDoor = (doorOpen === 1'b1);
    end
  end

  initial begin
    int n;
    int rises;
    reset = 1'b1;
    carButton = '0;
    assignedButton = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkResetOutputs("reset");
    repeat (20) tick();
    checkResetOutputs("idle_hold");

    // Car call to floor 5 from floor 1.
    pushStop(3'd5, 14'd0, 2'b10);
    carButton = 7'h10;
    tick();
    carButton = 7'h00;
    check("s2_lamp_latched", carLamp, 7'h10);
    tick();
    check("s2_dir_up", direction, 2'b10);
    waitFloor("s2_floor2", 3'd2, n);
    check("s2_step2", n, TRAVEL);
    waitFloor("s2_floor3", 3'd3, n);
    check("s2_step3", n, TRAVEL);
    waitFloor("s2_floor4", 3'd4, n);
    check("s2_step4", n, TRAVEL);
    waitFloor("s2_floor5", 3'd5, n);
    check("s2_step5", n, TRAVEL);
    check("s2_door_at_arrival", doorOpen, 1'b1);
    check("s2_lamp_cleared", carLamp, 7'h00);
    check("s2_served_none", servedButton, 14'd0);
    waitDoorCycle("s2_door_done");
    check("s2_dir_stop", direction, 2'b00);

    // Floor 4 UP then floor 6 DOWN with reversal service.
    doReset();
    pushStop(3'd4, 14'h0080, 2'b10);
    pushStop(3'd6, 14'h0400, 2'b10);
    assignedButton = 14'h0480;
    tick();
    waitDoorCycle("s3_stop4");
    waitDoorCycle("s3_stop6");
    check("s3_dir_stop", direction, 2'b00);
    check("s3_floor", currentFloor, 3'd6);

    // Pass a hall DOWN call on the way up, serve it on the way back.
    doReset();
    pushStop(3'd6, 14'h0000, 2'b10);
    pushStop(3'd4, 14'h0040, 2'b01);
    carButton = 7'h20;
    assignedButton = 14'h0040;
    tick();
    carButton = 7'h00;
    waitDoorCycle("s4_stop6");
    waitDoorCycle("s4_stop4");
    tick();
    check("s4_dir_stop", direction, 2'b00);
    check("s4_floor", currentFloor, 3'd4);

    // Hall call held at the idle floor, released two cycles after service.
    doReset();
    pushStop(3'd2, 14'h0000, 2'b10);
    carButton = 7'h02;
    tick();
    carButton = 7'h00;
    waitDoorCycle("s5_reach2");
    tick();
    check("s5_idle_dir", direction, 2'b00);
    autoClear = 1'b0;
    rises = doorRises;
    pushStop(3'd2, 14'h0004, 2'b00);
    assignedButton = 14'h0004;
    tick();
    check("s5_door_next_cycle", doorOpen, 1'b1);
    check("s5_served_pulse", servedButton, 14'h0004);
    tick();
    check("s5_served_one_cycle", servedButton, 14'h0000);
    tick();
    assignedButton = 14'h0000;
    repeat (15) tick();
    check("s5_single_door", doorRises - rises, 1);
    check("s5_door_closed", doorOpen, 1'b0);
    autoClear = 1'b1;

    // Nonexistent hall directions never move the car.
    doReset();
    assignedButton = 14'h2001;
    repeat (30) tick();
    check("s6_floor", currentFloor, 3'd1);
    check("s6_dir", direction, 2'b00);
    check("s6_door", doorOpen, 1'b0);

    // Reset in the middle of a move discards the pending call.
    doReset();
    carButton = 7'h40;
    tick();
    carButton = 7'h00;
    waitFloor("s7_floor3", 3'd3, n);
    reset = 1'b1;
    tick();
    checkResetOutputs("s7_midmove_reset");
    reset = 1'b0;
    repeat (20) tick();
    checkResetOutputs("s7_after_reset");

    check("scoreboard_empty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/elevator_car_controller.md
# elevator_car_controller

Per-car motion and door controller sitting directly downstream of the hall-call dispatcher: one instance per car consumes that car's 14-bit assigned hall-call vector plus its in-car buttons. It moves the car floor by floor and holds the door open at served floors. It returns current floor and direction to the dispatcher and pulses which hall calls it served so the hall-call register can clear them.

## Interface
- TRAVEL_CYCLES, 100: clock cycles to move one floor (≥2).
- DOOR_CYCLES, 200: clock cycles door stays open per stop (≥4).
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- assignedButton  in  14  hall calls assigned to this car; floor f (1..7) at bits [2f-1:2f-2], bit 2f-1 = UP, bit 2f-2 = DOWN.
- carButton  in  7  in-car floor buttons, bit f-1 = floor f, level or pulse.
- currentFloor  out  3  floor 1..7; 0 never driven.
- direction  out  2  STOP=2'b00, UP=2'b10, DOWN=2'b01; 2'b11 never driven.
- doorOpen  out  1  door open indicator.
- carLamp  out  7  latched in-car calls.
- servedButton  out  14  one-cycle pulse, same bit layout as assignedButton.

## Operation
- Reset: currentFloor=1, direction=STOP, doorOpen=0, carLamp=0, servedButton=0, state IDLE, counters 0. Reset mid-move or mid-door aborts immediately; pending car calls are discarded.
- carLamp[f-1] sets on carButton[f-1]=1 and stays set until served. It is not set while doorOpen=1 and f=currentFloor.
- Ignored hall bits: floor 7 UP (bit 13) and floor 1 DOWN (bit 0).
- Request terms, for floor x:
  - reqAbove(x): any carLamp or valid hall bit at a floor > x.
  - reqBelow(x): the same for floors < x.
  - reqHere: carLamp or either valid hall bit at currentFloor.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE (direction=STOP), priority order:
  - reqHere → DOOR_OPEN; serve car lamp and both hall bits at currentFloor.
  - else reqAbove → MOVE_UP, direction=UP.
  - else reqBelow → MOVE_DOWN, direction=DOWN.
  - else stay in IDLE.
- MOVE_UP: travel counter runs 0..TRAVEL_CYCLES-1. On the last count, currentFloor ← f = currentFloor+1.
  - Stop at f if carLamp[f-1], hall UP at f, or !reqAbove(f). Otherwise restart the counter and continue.
  - On stop → DOOR_OPEN. Serve carLamp[f-1] and hall UP at f. Also serve hall DOWN at f when !reqAbove(f) (reversal).
  - At f=7, reqAbove is 0, so the car always stops; it never increments past 7.
- MOVE_DOWN: mirror image. Decrement; stop on carLamp, hall DOWN, or !reqBelow(f). Serve hall UP at f only when !reqBelow(f). The car never goes below 1.
- DOOR_OPEN: doorOpen=1 for exactly DOOR_CYCLES cycles. Hall bits and car buttons at currentFloor are ignored in this state. On expiry, first match wins:
  - direction=UP and reqAbove → MOVE_UP.
  - direction=DOWN and reqBelow → MOVE_DOWN.
  - reqAbove → MOVE_UP, direction=UP.
  - reqBelow → MOVE_DOWN, direction=DOWN.
  - reqHere → IDLE; this reopens on the next cycle.
  - else IDLE, direction=STOP.
- servedButton: registered. Served bits are asserted for exactly the first DOOR_OPEN cycle, otherwise 0. Car lamps clear in that same cycle.
- direction is retained through DOOR_OPEN.

## Timing
- Registered outputs only; no combinational input→output path.
- IDLE with reqHere at cycle N: doorOpen=1 and servedButton valid at N+1.
- IDLE → MOVE_x at N+1 when the request is seen at N. currentFloor changes at N+1+TRAVEL_CYCLES.
- Arrival with stop: currentFloor changes and doorOpen/servedButton rise on the same edge.
- doorOpen falls DOOR_CYCLES cycles after rising. The next state is entered on that same edge.
- Upstream clears served hall bits within 3 cycles; DOOR_CYCLES≥4 guarantees no double service.
- Simultaneous carButton and assignedButton for the same floor are served in one stop. Both requests above and below from IDLE go UP.

## Test plan
Parameters for all scenarios: TRAVEL_CYCLES=4, DOOR_CYCLES=6.
- Reset, then idle: currentFloor=1, direction=00, doorOpen=0, carLamp=0, servedButton=0 held indefinitely. Assert reset mid-move at floor 3: all outputs return to reset values next cycle.
- carButton[4] pulse at floor 1: direction=10. currentFloor steps 2,3,4,5 every 4 cycles. doorOpen=1 for 6 cycles at floor 5, carLamp[4] clears, servedButton=0. Then IDLE with direction=00.
- assignedButton bit 7 (floor 4 UP) and bit 10 (floor 6 DOWN) from floor 1: stop at 4 with served bit 7 only. Continue to 6 with served bit 10 (reversal), then IDLE.
- Car at floor 3 moving UP toward carLamp floor 6, hall DOWN at floor 4 (bit 6) assigned: pass 4 without stopping, stop at 6. Then MOVE_DOWN, stop at 4 with served bit 6.
- assignedButton bit 2 (floor 2 DOWN) held at floor 2 in IDLE: doorOpen next cycle, servedButton bit 2 one cycle. Dispatcher releases the bit 2 cycles later: exactly one door cycle, no reopen.
- Bits 0 and 13 asserted alone: car stays IDLE at floor 1, never moves.
